// File: rtl/i2s_tx.sv
// I2S transmitter: 24-bit stereo samples in 32-bit slots, one-bit I2S delay,
// with a holding buffer in front of the frame registers.
module i2s_tx #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] lft_smpl,
  input  logic [23:0] rght_smpl,
  input  logic        smpl_vld,
  output logic        smpl_rdy,
  output logic        I2S_sclk,
  output logic        I2S_ws,
  output logic        I2S_data,
  output logic        underrun
);

  localparam int unsigned CNT_W    = $clog2(SCLK_DIV);
  localparam int unsigned SLOT_W   = 6;
  localparam int unsigned SMPL_W   = 24;
  localparam int unsigned HALF_DIV = SCLK_DIV / 2;

  typedef struct packed {
    logic [SMPL_W-1:0] lft;
    logic [SMPL_W-1:0] rght;
  } pair_t;

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              sclk_q, sclk_d;
  logic              ws_q,   ws_d;
  logic              data_q, data_d;
  logic              underrun_q, underrun_d;
  logic              full_q, full_d;
  pair_t             hold_q, hold_d;
  pair_t             frame_q, frame_d;

  logic              fall;
  logic              boundary;
  logic              accept;
  logic [4:0]        k;
  logic [4:0]        bit_idx;
  logic [SMPL_W-1:0] word;

  // Divider, slot sequencing, serializer and two-stage buffering
  always_comb begin
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    sclk_d     = sclk_q;
    ws_d       = ws_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_d     = hold_q;
    frame_d    = frame_q;

    fall     = (cnt_q == CNT_W'(SCLK_DIV - 1));
    boundary = fall && (slot_q == SLOT_W'(63));
    accept   = smpl_vld && !full_q;

    cnt_d  = fall ? '0 : cnt_q + CNT_W'(1);
    sclk_d = (cnt_d >= CNT_W'(HALF_DIV));
    slot_d = fall ? slot_q + SLOT_W'(1) : slot_q;

    // Serial outputs follow the slot being entered; frame_q is stable here
    // because slot 0 (the only slot coinciding with a frame load) sends 0.
    k       = slot_d[4:0];
    bit_idx = 5'(5'd24 - k);
    word    = slot_d[5] ? frame_q.rght : frame_q.lft;
    if (fall) begin
      ws_d = slot_d[5];
      if ((k >= 5'd1) && (k <= 5'd24)) begin
        data_d = word[bit_idx];
      end else begin
        data_d = 1'b0;
      end
    end

    if (accept) begin
      hold_d.lft  = lft_smpl;
      hold_d.rght = rght_smpl;
      full_d      = 1'b1;
    end

    // An accept in the boundary cycle lands in the buffer for the next frame
    if (boundary) begin
      underrun_d = !full_q;
      if (full_q) begin
        frame_d = hold_q;
        full_d  = 1'b0;
      end
    end
  end

  // State registers; ws resets high so the first fall event starts a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      slot_q     <= SLOT_W'(63);
      sclk_q     <= 1'b0;
      ws_q       <= 1'b1;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_q     <= '0;
      frame_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      sclk_q     <= sclk_d;
      ws_q       <= ws_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      frame_q    <= frame_d;
    end
  end

  assign smpl_rdy = !full_q;
  assign I2S_sclk = sclk_q;
  assign I2S_ws   = ws_q;
  assign I2S_data = data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with a receiver-model scoreboard.
`timescale 1ns/1ps
module tb_i2s_tx;

  localparam int SCLK_DIV = 32;
  localparam int FRAME    = 64 * SCLK_DIV;
  localparam int B0       = SCLK_DIV;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] lft_smpl = '0;
  logic [23:0] rght_smpl = '0;
  logic        smpl_vld = 1'b0;
  logic        smpl_rdy;
  logic        I2S_sclk;
  logic        I2S_ws;
  logic        I2S_data;
  logic        underrun;

  i2s_tx #(.SCLK_DIV(SCLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
    .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy), .I2S_sclk(I2S_sclk),
    .I2S_ws(I2S_ws), .I2S_data(I2S_data), .underrun(underrun)
  );

  always #5 clk = ~clk;

  pair_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    e_cnt = 0;
  int    ur_hi = 0;
  logic  data_one = 1'b0;

  // Rising clk edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_cnt <= 0;
    else        e_cnt <= e_cnt + 1;
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, e_cnt);
    end
  endtask

  // Receiver model and timing monitor
  logic        sclk_prev = 1'b0;
  logic        ws_prev = 1'b1;
  logic        rx_ws = 1'b1;
  int          k = 31;
  logic        got_left = 1'b0;
  logic [23:0] sh = '0;
  logic [23:0] rx_l = '0;
  int          ws_e = 0;
  logic        ws_armed = 1'b0;
  logic        ws_val = 1'b0;
  pair_t       p;

  always @(negedge clk) begin
    if (!rst_n) begin
      sclk_prev = 1'b0; ws_prev = 1'b1; rx_ws = 1'b1; k = 31;
      got_left = 1'b0; ws_armed = 1'b0;
    end else begin
      if (underrun) begin
        ur_hi++;
        chk("underrun_timing", 48'((e_cnt - B0) % FRAME), 48'd0);
      end
      if (I2S_data) data_one = 1'b1;
      if (I2S_ws !== ws_prev) begin
        ws_e = e_cnt; ws_val = I2S_ws; ws_armed = 1'b1;
      end
      if (ws_armed && e_cnt == ws_e + SCLK_DIV - 1)
        chk("pre_msb_zero", 48'(I2S_data), 48'd0);
      if (ws_armed && e_cnt == ws_e + SCLK_DIV) begin
        if (exp_q.size() > 0)
          chk("msb_timing", 48'(I2S_data), 48'(ws_val ? exp_q[0].r[23] : exp_q[0].l[23]));
        ws_armed = 1'b0;
      end
      ws_prev = I2S_ws;
      if (I2S_sclk && !sclk_prev) begin
        if (I2S_ws != rx_ws) begin
          rx_ws = I2S_ws; k = 0;
        end else begin
          k++;
        end
        if (k >= 1 && k <= 24) begin
          sh = {sh[22:0], I2S_data};
          if (k == 24) begin
            if (!rx_ws) begin
              rx_l = sh; got_left = 1'b1;
            end else if (got_left) begin
              got_left = 1'b0;
              if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_frame: got %h/%h expected none", rx_l, sh);
              end else begin
                p = exp_q.pop_front();
                chk("rx_left", 48'(rx_l), 48'(p.l));
                chk("rx_right", 48'(sh), 48'(p.r));
              end
            end
          end
        end else if (k == 0 || (k >= 25 && k <= 31)) begin
          chk("pad_zero", 48'(I2S_data), 48'd0);
        end
      end
      sclk_prev = I2S_sclk;
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    ur_hi = 0; data_one = 1'b0;
  endtask

  task automatic wait_edge(input int e);
    do @(negedge clk); while (e_cnt != e);
  endtask

  // Drive one offer so that it is sampled at rising edge e
  task automatic offer(input int e, input logic [23:0] l, input logic [23:0] r);
    do @(negedge clk); while (e_cnt != e - 1);
    lft_smpl = l; rght_smpl = r; smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
  endtask

  task automatic end_test(input string name, input int exp_ur);
    chk({name, "_queue_empty"}, 48'(exp_q.size()), 48'd0);
    chk({name, "_underruns"}, 48'(ur_hi), 48'(exp_ur));
    exp_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sclk", 48'(I2S_sclk), 48'd0);
    chk("rst_ws", 48'(I2S_ws), 48'd1);
    chk("rst_data", 48'(I2S_data), 48'd0);
    chk("rst_rdy", 48'(smpl_rdy), 48'd1);
    chk("rst_underrun", 48'(underrun), 48'd0);

    // Single pair loaded at the first boundary
    do_reset();
    exp_q.push_back('{l: 24'hA5A5A5, r: 24'h5A5A5A});
    offer(5, 24'hA5A5A5, 24'h5A5A5A);
    wait_edge(B0 + FRAME - 20);
    end_test("basic", 0);

    // Idle: underrun each frame, silent data
    do_reset();
    exp_q.push_back('{l: 24'h0, r: 24'h0});
    exp_q.push_back('{l: 24'h0, r: 24'h0});
    wait_edge(B0 + 2 * FRAME + 10);
    chk("idle_data_zero", 48'(data_one), 48'd0);
    end_test("idle", 3);

    // Offer while full is dropped
    do_reset();
    exp_q.push_back('{l: 24'h123456, r: 24'h654321});
    offer(5, 24'h123456, 24'h654321);
    chk("full_rdy_low", 48'(smpl_rdy), 48'd0);
    offer(10, 24'hABCDEF, 24'hFEDCBA);
    wait_edge(B0 + FRAME - 20);
    end_test("drop", 0);

    // One pair per frame with extreme values
    do_reset();
    exp_q.push_back('{l: 24'h000001, r: 24'h0F0F0E});
    offer(5, 24'h000001, 24'h0F0F0E);
    exp_q.push_back('{l: 24'h7FFFFF, r: 24'h70F0F0});
    offer(B0 + 100, 24'h7FFFFF, 24'h70F0F0);
    exp_q.push_back('{l: 24'h800000, r: 24'h8F0F0F});
    offer(B0 + FRAME + 100, 24'h800000, 24'h8F0F0F);
    exp_q.push_back('{l: 24'hFFFFFF, r: 24'hF0F0F0});
    offer(B0 + 2 * FRAME + 100, 24'hFFFFFF, 24'hF0F0F0);
    wait_edge(B0 + 4 * FRAME - 20);
    end_test("seq", 0);

    // Reset at slot 40 loses the buffered pair
    do_reset();
    offer(5, 24'h111111, 24'h222222);
    offer(100, 24'h333333, 24'h444444);
    wait_edge(B0 + 40 * SCLK_DIV + 16);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", 48'(I2S_sclk), 48'd0);
    chk("midrst_ws", 48'(I2S_ws), 48'd1);
    chk("midrst_data", 48'(I2S_data), 48'd0);
    chk("midrst_rdy", 48'(smpl_rdy), 48'd1);
    chk("midrst_underrun", 48'(underrun), 48'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    ur_hi = 0; data_one = 1'b0;
    exp_q.push_back('{l: 24'h0, r: 24'h0});
    wait_edge(B0 + FRAME - 20);
    end_test("midrst", 1);

    // Offer exactly on an empty boundary: underrun now, pair next frame
    do_reset();
    exp_q.push_back('{l: 24'h0, r: 24'h0});
    exp_q.push_back('{l: 24'hDEADBE, r: 24'hEF0123});
    offer(B0, 24'hDEADBE, 24'hEF0123);
    chk("bnd_accept_rdy", 48'(smpl_rdy), 48'd0);
    wait_edge(B0 + 2 * FRAME - 20);
    end_test("bnd_offer", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SCLK_DIV, default 32, is the number of clk cycles per I2S_sclk period; it SHALL be even and at least 4.
REQ-002 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 lft_smpl  input  24  left sample, two's complement.
REQ-005 rght_smpl  input  24  right sample, two's complement.
REQ-006 smpl_vld  input  1  sample pair offered; it SHALL be accepted only in a cycle where smpl_rdy=1.
REQ-007 smpl_rdy  output  1  holding buffer is empty, so a pair can be accepted.
REQ-008 I2S_sclk  output  1  bit clock, 50% duty, period SCLK_DIV clk cycles.
REQ-009 I2S_ws  output  1  word select: 0 = left half, 1 = right half.
REQ-010 I2S_data  output  1  serial data, MSB first.
REQ-011 underrun  output  1  one-clk pulse when a frame starts with an empty buffer.

Function
REQ-012 The divider counter cnt SHALL count 0..SCLK_DIV-1 and then wrap.
- I2S_sclk=0 while cnt<SCLK_DIV/2; I2S_sclk=1 otherwise.
- A "fall event" is the cycle in which cnt wraps from SCLK_DIV-1 to 0.
REQ-013 Slot counter slot (0..63) SHALL advance by 1 on every fall event and wrap from 63 to 0; one frame is 64 slots, which is 64*SCLK_DIV clk cycles.
REQ-014 I2S_ws and I2S_data SHALL be registered and change only on fall events, so they are stable across each rising edge of I2S_sclk.
REQ-015 I2S_ws SHALL be 0 for slots 0..31 and 1 for slots 32..63.
REQ-016 Within each half, with k = slot mod 32, the data slots SHALL be as follows (one-bit I2S delay):
- k=0: I2S_data=0.
- k=1..24: I2S_data = bit [24-k] of that half's frame sample.
- k=25..31: I2S_data=0.
REQ-017 Buffering SHALL use a two-stage scheme: a holding buffer (48 bits plus a full flag) and frame registers (48 bits).
REQ-018 smpl_rdy SHALL equal the inverse of the full flag.
- smpl_vld & smpl_rdy loads the holding buffer and sets full on the next edge.
- smpl_vld while smpl_rdy=0 SHALL be ignored; the buffer contents are unchanged.
REQ-019 Frame boundary (the fall event where slot goes 63 to 0) with full=1: the frame registers SHALL load from the buffer and full SHALL clear.
REQ-020 Frame boundary with full=0: the frame registers SHALL hold their previous values, so the last pair is repeated, and underrun SHALL pulse high for exactly that one clk.
REQ-021 If smpl_vld and a frame boundary fall in the same cycle:
- smpl_rdy is 0 in that cycle when full=1, so the offer is ignored.
- When full=0 the offer SHALL be accepted into the buffer, underrun SHALL still pulse, and the new pair is sent in the next frame.
REQ-022 Latency: a pair accepted before boundary B SHALL have its left MSB on I2S_data starting at the fall event for slot 1, which is SCLK_DIV clk cycles after B.
REQ-023 All arithmetic SHALL be unsigned counter logic; cnt width is clog2(SCLK_DIV) and slot width is 6 bits.

Reset
REQ-024 On rst_n low, outputs SHALL immediately take these values:
- I2S_sclk=0, I2S_ws=1, I2S_data=0.
- smpl_rdy=1, underrun=0.
REQ-025 On rst_n low, internal state SHALL immediately take these values:
- cnt=0.
- slot=63, so the first fall event after release is a frame boundary.
- full=0, frame registers=0.
REQ-026 Reset asserted mid-frame SHALL abort the transfer, discard any buffered pair, and restart framing from REQ-024 and REQ-025.

Verification
REQ-027 With SCLK_DIV=32, apply reset, then offer lft=24'hA5A5A5 and rght=24'h5A5A5A before the first boundary.
- The first boundary (clk 32 after release) loads the pair.
- An I2S receiver model samples 24'hA5A5A5 with ws=0 and 24'h5A5A5A with ws=1.
- underrun stays 0.
REQ-028 Release reset with no samples offered.
- underrun pulses once per 2048 clks.
- I2S_data stays 0 throughout.
REQ-029 Offer a second pair while smpl_rdy=0 (buffer full): the second pair is dropped, and the first pair is transmitted unchanged.
REQ-030 Feed one pair per frame, sequence 24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF.
- Each value is received exactly once, in order.
- The bench checks MSB timing: bit 23 is on I2S_data 32 clks after each ws edge.
REQ-031 Assert rst_n for 3 clks at slot 40 of a frame.
- All outputs go to reset values within the same cycle.
- The frame restarts after release.
- The buffered pair is lost.
REQ-032 Drive smpl_vld exactly on a boundary cycle with full=0.
- underrun pulses.
- The offered pair appears on the next frame, not the current one.
